// File: rtl/apb_req_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter that shares one APB master request port among NUM_REQ requesters.
// Latency: grant one edge after req_valid is seen in IDLE; resp_valid one edge after the PREADY access edge.
// Backpressure: one transfer in flight; other requesters hold req_valid until their req_grant pulse.
//
// Ports:
//   PCLK, PRESETn                  clock, synchronous active-low reset
//   req_valid/write/addr/wdata/
//   req_strb/prot                  flattened per-requester requests (requester i at slice i)
//   req_grant                      one-hot accept pulse, first ISSUE cycle only
//   resp_valid/rdata/err           one-hot completion pulse to the owner, captured PRDATA/PSLVERR
//   transfer, SWRITE..SPROT        request towards the APB master, fields stable from grant through RESP
//   PSEL, PENABLE, PREADY,
//   PSLVERR, PRDATA                observed APB bus phase signals
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]            req_prot,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic                            resp_err,
  output logic                            transfer,
  output logic                            SWRITE,
  output logic [ADDR_WIDTH-1:0]           SADDR,
  output logic [DATA_WIDTH-1:0]           SWDATA,
  output logic [DATA_WIDTH/8-1:0]         SSTRB,
  output logic [2:0]                      SPROT,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PREADY,
  input  logic                            PSLVERR,
  input  logic [DATA_WIDTH-1:0]           PRDATA
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
    logic [2:0]            prot;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state;
  hdr_t   cur;
  // last_grant doubles as the owner of the transfer in flight: it only moves on a grant.
  idx_t   last_grant;
  idx_t   win_idx;
  idx_t   cand;
  logic   win_found;
  hdr_t   req_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_a[g] = {req_write[g],
                       req_addr[g*ADDR_WIDTH +: ADDR_WIDTH],
                       req_wdata[g*DATA_WIDTH +: DATA_WIDTH],
                       req_strb[g*SW +: SW],
                       req_prot[g*3 +: 3]};
  end

  // Round-robin pick: scan from the requester after last_grant, wrapping, first active wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = idx_t'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
    return NUM_REQ'(1) << i;
  endfunction

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= idx_t'(NUM_REQ - 1);
      cur        <= '0;
      req_grant  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      transfer   <= 1'b0;
    end else begin
      // Both pulses are single-cycle; only the transitions below raise them.
      req_grant  <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cur        <= req_a[win_idx];
            req_grant  <= onehot(win_idx);
            last_grant <= win_idx;
            transfer   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Setup phase on the bus means the master has taken the request.
          if (PSEL && !PENABLE) begin
            transfer <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (PSEL && PENABLE && PREADY) begin
            resp_rdata <= cur.write ? '0 : PRDATA;
            resp_err   <= PSLVERR;
            resp_valid <= onehot(last_grant);
            state      <= RESP;
          end
        end
        RESP: begin
          // No arbitration on this edge; the next grant needs a full IDLE edge.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SWRITE = cur.write;
  assign SADDR  = cur.addr;
  assign SWDATA = cur.wdata;
  assign SSTRB  = cur.strb;
  assign SPROT  = cur.prot;

endmodule

// File: tb/tb_apb_req_arbiter.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for apb_req_arbiter with an APB bus/slave model and a cycle model.
// Latency: model expectations are formed at each rising edge and compared on the falling edge.
// Backpressure: the slave model inserts a configurable number of wait states per access.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef logic [1:0] rid_t;

  logic            PCLK;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*4-1:0]  req_strb;
  logic [N*3-1:0]  req_prot;
  logic [N-1:0]    req_grant, resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err, transfer, SWRITE;
  logic [AW-1:0]   SADDR;
  logic [DW-1:0]   SWDATA;
  logic [3:0]      SSTRB;
  logic [2:0]      SPROT;
  logic            PSEL, PENABLE, PREADY, PSLVERR;
  logic [DW-1:0]   PRDATA;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .transfer(transfer), .SWRITE(SWRITE), .SADDR(SADDR),
    .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester intent and bus/slave configuration.
  logic        r_write [N];
  logic [31:0] r_addr  [N];
  logic [31:0] r_wdata [N];
  logic [3:0]  r_strb  [N];
  logic [2:0]  r_prot  [N];
  int          pend    [N];
  logic [31:0] slv_mem [64];
  logic        slv_err;
  int          slv_waits;
  int          wleft;
  int          cyc;

  int          g_q[$], g_cyc[$], rs_idx[$], rs_cyc[$];
  logic [31:0] rs_data[$];
  logic        rs_err[$];

  function automatic int oh2i(input logic [N-1:0] v);
    for (bit [2:0] i = 0; i < 3'(N); i++) if (v[i[1:0]]) return int'(i);
    return -1;
  endfunction

  function automatic int g_at(input int k);     return (k < g_q.size())    ? g_q[k]    : -1; endfunction
  function automatic int gc_at(input int k);    return (k < g_cyc.size())  ? g_cyc[k]  : -1000; endfunction
  function automatic int ri_at(input int k);    return (k < rs_idx.size()) ? rs_idx[k] : -1; endfunction
  function automatic int rc_at(input int k);    return (k < rs_cyc.size()) ? rs_cyc[k] : 1000000; endfunction
  function automatic logic [31:0] rd_at(input int k); return (k < rs_data.size()) ? rs_data[k] : 32'hFFFF_FFFF; endfunction
  function automatic logic re_at(input int k);  return (k < rs_err.size()) ? rs_err[k] : 1'bx; endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int          m_ptr;
  bit          m_busy, m_setup, m_cool;
  rid_t        m_own;
  logic [31:0] m_mem [64];
  logic [N-1:0] e_grant, e_resp;
  logic        e_transfer, e_err, e_write;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_strb;
  logic [2:0]  e_prot;

  // Winner is the active requester at the smallest circular distance after the pointer.
  function automatic int rr_pick(input logic [N-1:0] rv, input int ptr);
    int best = -1;
    int bestd = N;
    for (bit [2:0] i = 0; i < 3'(N); i++) begin
      int d;
      d = (int'(i) - ptr - 1 + 2*N) % N;
      if (rv[i[1:0]] && d < bestd) begin
        bestd = d;
        best  = int'(i);
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    int w;
    if (!PRESETn) begin
      {e_grant, e_resp, e_transfer, e_err, e_write} = '0;
      {e_rdata, e_addr, e_wdata, e_strb, e_prot} = '0;
      m_ptr = N - 1; m_busy = 0; m_setup = 0; m_cool = 0;
    end else begin
      e_grant = '0;
      e_resp  = '0;
      if (m_cool) begin
        m_cool = 0;
      end else if (!m_busy) begin
        if (req_valid != '0) begin
          w = rr_pick(req_valid, m_ptr);
          m_ptr = w;
          m_own = rid_t'(w);
          e_grant = N'(1) << w;
          e_transfer = 1'b1;
          e_write = r_write[m_own]; e_addr = r_addr[m_own]; e_wdata = r_wdata[m_own];
          e_strb  = r_strb[m_own];  e_prot = r_prot[m_own];
          m_busy = 1; m_setup = 0;
        end
      end else if (!m_setup) begin
        if (PSEL && !PENABLE) begin
          m_setup = 1;
          e_transfer = 1'b0;
        end
      end else if (PSEL && PENABLE && PREADY) begin
        e_resp  = N'(1) << m_own;
        e_err   = slv_err;
        e_rdata = e_write ? 32'h0 : m_mem[e_addr[7:2]];
        if (e_write && !slv_err) m_mem[e_addr[7:2]] = e_wdata;
        m_busy = 0; m_cool = 1;
      end
    end
  endtask

  initial begin
    m_mem = '{default: 32'h0};
    forever begin
      @(posedge PCLK);
      model_edge();
      @(negedge PCLK);
      chk("grant",      64'(req_grant),  64'(e_grant));
      chk("resp_valid", 64'(resp_valid), 64'(e_resp));
      chk("transfer",   64'(transfer),   64'(e_transfer));
      chk("resp_rdata", 64'(resp_rdata), 64'(e_rdata));
      chk("resp_err",   64'(resp_err),   64'(e_err));
      chk("SWRITE",     64'(SWRITE),     64'(e_write));
      chk("SADDR",      64'(SADDR),      64'(e_addr));
      chk("SWDATA",     64'(SWDATA),     64'(e_wdata));
      chk("SSTRB",      64'(SSTRB),      64'(e_strb));
      chk("SPROT",      64'(SPROT),      64'(e_prot));
    end
  end

  // ---------------- stimulus: requesters and APB bus/slave ----------------
  task automatic drive_req();
    for (bit [2:0] i = 0; i < 3'(N); i++) req_valid[i[1:0]] = (pend[i[1:0]] > 0);
    req_write = {r_write[3], r_write[2], r_write[1], r_write[0]};
    req_addr  = {r_addr[3],  r_addr[2],  r_addr[1],  r_addr[0]};
    req_wdata = {r_wdata[3], r_wdata[2], r_wdata[1], r_wdata[0]};
    req_strb  = {r_strb[3],  r_strb[2],  r_strb[1],  r_strb[0]};
    req_prot  = {r_prot[3],  r_prot[2],  r_prot[1],  r_prot[0]};
  endtask

  task automatic set_req(input rid_t i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p, input int cnt);
    r_write[i] = wr; r_addr[i] = a; r_wdata[i] = d; r_strb[i] = s; r_prot[i] = p;
    pend[i] = cnt;
    drive_req();
  endtask

  task automatic step();
    @(negedge PCLK);
    cyc++;
    if (req_grant != '0) begin g_q.push_back(oh2i(req_grant)); g_cyc.push_back(cyc); end
    if (resp_valid != '0) begin
      rs_idx.push_back(oh2i(resp_valid)); rs_cyc.push_back(cyc);
      rs_data.push_back(resp_rdata); rs_err.push_back(resp_err);
    end
    for (bit [2:0] i = 0; i < 3'(N); i++)
      if (req_grant[i[1:0]] && pend[i[1:0]] > 0) pend[i[1:0]]--;
    drive_req();
    if (!PRESETn) begin
      PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = 32'h0; wleft = 0;
    end else if (PSEL && PENABLE && PREADY) begin
      if (SWRITE && !slv_err) slv_mem[SADDR[7:2]] = SWDATA;
      PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = 32'h0;
    end else if (PSEL) begin
      if (!PENABLE) begin
        PENABLE = 1; wleft = slv_waits;
      end else begin
        wleft--;
      end
      PREADY  = (wleft <= 0);
      PRDATA  = (PREADY && !SWRITE) ? slv_mem[SADDR[7:2]] : 32'hDEAD_BEEF;
      PSLVERR = PREADY ? slv_err : 1'b0;
    end else if (transfer) begin
      PSEL = 1;
    end
  endtask

  task automatic wait_resp(input int n);
    int budget = 200;
    while (rs_idx.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk("resp_timeout", 64'(rs_idx.size() >= n), 64'(1));
  endtask

  int gb, rb, bud;
  int ord [8];

  initial begin
    PRESETn = 0; PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = 32'h0;
    slv_err = 0; slv_waits = 0; wleft = 0; cyc = 0;
    slv_mem = '{default: 32'h0};
    for (bit [2:0] i = 0; i < 3'(N); i++) begin
      pend[i[1:0]] = 0; r_write[i[1:0]] = 0; r_addr[i[1:0]] = 0;
      r_wdata[i[1:0]] = 0; r_strb[i[1:0]] = 0; r_prot[i[1:0]] = 0;
    end
    drive_req();
    repeat (3) step();
    chk("rst_grant",    64'(req_grant),  64'(0));
    chk("rst_resp",     64'(resp_valid), 64'(0));
    chk("rst_transfer", 64'(transfer),   64'(0));
    chk("rst_rdata",    64'(resp_rdata), 64'(0));
    chk("rst_err",      64'(resp_err),   64'(0));
    chk("rst_saddr",    64'(SADDR),      64'(0));
    PRESETn = 1;
    step();

    // Single zero-wait write from requester 0.
    set_req(2'd0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b010, 1);
    wait_resp(1); repeat (2) step();
    chk("w0_grant",  64'(g_at(0)), 64'(0));
    chk("w0_owner",  64'(ri_at(0)), 64'(0));
    chk("w0_err",    64'(re_at(0)), 64'(0));
    chk("w0_lat",    64'(rc_at(0) - gc_at(0)), 64'(2));
    chk("w0_single", 64'(rs_idx.size()), 64'(1));

    // Read back through requester 2.
    set_req(2'd2, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1);
    wait_resp(2); repeat (2) step();
    chk("r2_owner", 64'(ri_at(1)), 64'(2));
    chk("r2_data",  64'(rd_at(1)), 64'(32'hA5A5_0001));

    // Slave error on requester 3; also leaves the pointer at 3.
    slv_err = 1;
    set_req(2'd3, 1'b1, 32'h30, 32'hBAD0_0003, 4'hF, 3'b001, 1);
    wait_resp(3); repeat (2) step();
    slv_err = 0;
    chk("e3_owner", 64'(ri_at(2)), 64'(3));
    chk("e3_err",   64'(re_at(2)), 64'(1));

    // All four held for two transfers each.
    gb = g_q.size(); rb = rs_idx.size();
    for (bit [2:0] i = 0; i < 3'(N); i++)
      set_req(i[1:0], 1'b1, 32'h20 + 32'(i) * 4, 32'h1000_0000 + 32'(i), 4'hF, i, 2);
    wait_resp(rb + 8); repeat (2) step();
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 8; k++) chk("rr_order", 64'(g_at(gb + k)), 64'(ord[k]));
    for (int k = 0; k < 7; k++) chk("rr_no_overlap", 64'(rc_at(rb + k) < gc_at(gb + k + 1)), 64'(1));
    chk("rr_err_cleared", 64'(re_at(rb)), 64'(0));

    // Three wait states on a read from requester 1.
    slv_waits = 3;
    rb = rs_idx.size();
    set_req(2'd1, 1'b0, 32'h24, 32'h0, 4'h0, 3'b000, 1);
    wait_resp(rb + 1); repeat (3) step();
    slv_waits = 0;
    chk("ws_data",   64'(rd_at(rb)), 64'(32'h1000_0001));
    chk("ws_lat",    64'(rc_at(rb) - gc_at(g_q.size() - 1)), 64'(5));
    chk("ws_single", 64'(rs_idx.size()), 64'(rb + 1));

    // Reset while the slave is stalling an access.
    slv_waits = 6;
    gb = g_q.size(); rb = rs_idx.size();
    set_req(2'd0, 1'b1, 32'h3C, 32'h5555_AAAA, 4'h3, 3'b000, 1);
    bud = 50;
    while (g_q.size() <= gb && bud > 0) begin step(); bud--; end
    chk("rst_pre_grant", 64'(g_q.size()), 64'(gb + 1));
    repeat (2) step();
    PRESETn = 0;
    set_req(2'd1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1);
    set_req(2'd3, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 1);
    step();
    chk("mid_rst_transfer", 64'(transfer),   64'(0));
    chk("mid_rst_resp",     64'(resp_valid), 64'(0));
    chk("mid_rst_grant",    64'(req_grant),  64'(0));
    chk("mid_rst_rdata",    64'(resp_rdata), 64'(0));
    chk("mid_rst_saddr",    64'(SADDR),      64'(0));
    PRESETn = 1;
    slv_waits = 0;
    wait_resp(rb + 2); repeat (2) step();
    chk("post_rst_first",  64'(g_at(gb + 1)), 64'(1));
    chk("post_rst_second", 64'(g_at(gb + 2)), 64'(3));
    chk("post_rst_resp_a", 64'(ri_at(rb)), 64'(1));
    chk("post_rst_data_a", 64'(rd_at(rb)), 64'(32'hA5A5_0001));
    chk("post_rst_resp_b", 64'(ri_at(rb + 1)), 64'(3));
    chk("post_rst_data_b", 64'(rd_at(rb + 1)), 64'(0));
    chk("post_rst_count",  64'(rs_idx.size()), 64'(rb + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
